// File: rtl/pic_pkg.sv
// Shared FSM type, OCW2 command codes and strobe indices for the 8259A sequencer.
package pic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK1 = 2'd1,
    ST_ACK2 = 2'd2
  } pic_state_e;

  localparam logic [2:0] NS_EOI = 3'b001;
  localparam logic [2:0] SP_EOI = 3'b011;

  localparam int ICW1_BIT = 0;
  localparam int ICW2_BIT = 1;
  localparam int ICW3_BIT = 2;
  localparam int ICW4_BIT = 3;
  localparam int OCW1_BIT = 0;
  localparam int OCW2_BIT = 1;
  localparam int OCW3_BIT = 2;

  localparam logic [2:0] SPURIOUS_LVL = 3'd7;

  // One-hot decode of an interrupt level.
  function automatic logic [7:0] lvl_mask(input logic [2:0] lvl);
    lvl_mask = 8'h01 << lvl;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Combinational fixed-priority finder: reports the lowest set bit (IR0 is highest priority).
module pic_priority_resolver #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic             found_o,
  output logic [2:0]       idx_o
);

  // Scan from the lowest priority upward so the lowest set index is left standing.
  always_comb begin
    found_o = 1'b0;
    idx_o   = 3'd0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      found_o = found_o | vec_i[i];
      idx_o   = vec_i[i] ? 3'(i) : idx_o;
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// 8259A interrupt core: IRR/ISR/IMR, fixed priority, INT and the two-pulse INTA handshake.
// Optional feature: define PIC_AUTO_EOI_EN to enable ICW4 automatic EOI.
module interrupt_sequencer
  import pic_pkg::*;
#(
  parameter int NUM_IR = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IR-1:0] ir,
  input  logic              inta_n,
  input  logic [3:0]        icw_wr,
  input  logic [2:0]        ocw_wr,
  input  logic [7:0]        wr_data,
  output logic              int_out,
  output logic [7:0]        interrupt_vector,
  output logic              iv_ready,
  output logic [NUM_IR-1:0] irr,
  output logic [NUM_IR-1:0] isr,
  output logic [NUM_IR-1:0] imr
);

  pic_state_e        state_q, state_d;
  logic [NUM_IR-1:0] irr_q, irr_d;
  logic [NUM_IR-1:0] isr_q, isr_d;
  logic [NUM_IR-1:0] imr_q, imr_d;
  logic [NUM_IR-1:0] ir_prev_q, ir_prev_d;
  logic              ltim_q, ltim_d;
  logic [4:0]        base_q, base_d;
  logic [2:0]        level_q, level_d;
  logic [7:0]        vector_q, vector_d;
  logic              int_out_q, int_out_d;
  logic              ack2_q, ack2_d;
  logic              inta_n_q;

  logic              icw1_s;
  logic              inta_fall_s;
  logic              inta_rise_s;
  logic [NUM_IR-1:0] req_set_s;
  logic [NUM_IR-1:0] masked_s;
  logic              pend_found_s;
  logic [2:0]        pend_idx_s;
  logic              isr_found_s;
  logic [2:0]        isr_idx_s;
  logic              qualify_s;
  logic [NUM_IR-1:0] eoi_clr_s;
  logic [NUM_IR-1:0] ack_set_s;
  logic [NUM_IR-1:0] aeoi_clr_s;
  logic              aeoi_s;
  logic              unused_s;

  assign icw1_s      = icw_wr[ICW1_BIT];
  assign inta_fall_s = inta_n_q & ~inta_n;
  assign inta_rise_s = ~inta_n_q & inta_n;
  assign req_set_s   = ltim_q ? ir : (ir & ~ir_prev_q);
  assign masked_s    = irr_q & ~imr_q;

  pic_priority_resolver #(.WIDTH(NUM_IR)) u_irr_prio (
    .vec_i   (masked_s),
    .found_o (pend_found_s),
    .idx_o   (pend_idx_s)
  );

  pic_priority_resolver #(.WIDTH(NUM_IR)) u_isr_prio (
    .vec_i   (isr_q),
    .found_o (isr_found_s),
    .idx_o   (isr_idx_s)
  );

  // A request is only presented when it outranks everything already in service.
  assign qualify_s = pend_found_s & (~isr_found_s | (pend_idx_s < isr_idx_s));

`ifdef PIC_AUTO_EOI_EN
  logic aeoi_q;

  // AEOI mode bit, loaded from ICW4.
  always_ff @(posedge clk) begin
    if (rst) begin
      aeoi_q <= 1'b0;
    end else if (!icw1_s && icw_wr[ICW4_BIT]) begin
      aeoi_q <= wr_data[1];
    end
  end

  assign aeoi_s   = aeoi_q;
  assign unused_s = ^{icw_wr[ICW3_BIT], ocw_wr[OCW3_BIT]};
`else
  assign aeoi_s   = 1'b0;
  assign unused_s = ^{icw_wr[ICW3_BIT], icw_wr[ICW4_BIT], ocw_wr[OCW3_BIT]};
`endif

  // OCW2 end-of-interrupt decode; codes other than NS/SP EOI are ignored.
  always_comb begin
    eoi_clr_s = 8'h00;
    if (ocw_wr[OCW2_BIT]) begin
      case (wr_data[7:5])
        NS_EOI:  eoi_clr_s = isr_found_s ? lvl_mask(isr_idx_s) : 8'h00;
        SP_EOI:  eoi_clr_s = lvl_mask(wr_data[2:0]);
        default: eoi_clr_s = 8'h00;
      endcase
    end else begin
      eoi_clr_s = 8'h00;
    end
  end

  // Handshake FSM: the level is frozen at the first INTA, the vector follows it.
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    vector_d   = vector_q;
    ack_set_s  = 8'h00;
    aeoi_clr_s = 8'h00;
    if (icw1_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (inta_fall_s) begin
            state_d = ST_ACK1;
            if (qualify_s) begin
              level_d   = pend_idx_s;
              ack_set_s = lvl_mask(pend_idx_s);
            end else begin
              level_d = SPURIOUS_LVL;
            end
            vector_d = {base_q, level_d};
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ACK1: begin
          if (inta_fall_s) begin
            state_d = ST_ACK2;
          end else begin
            state_d = ST_ACK1;
          end
        end
        ST_ACK2: begin
          if (inta_rise_s) begin
            state_d    = ST_IDLE;
            aeoi_clr_s = aeoi_s ? lvl_mask(level_q) : 8'h00;
          end else begin
            state_d = ST_ACK2;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Register next-state: EOI clears before the acknowledge sets, ack clear beats a new edge.
  always_comb begin
    if (icw1_s) begin
      irr_d     = 8'h00;
      isr_d     = 8'h00;
      imr_d     = 8'h00;
      ir_prev_d = 8'h00;
      ltim_d    = wr_data[3];
      base_d    = base_q;
      int_out_d = 1'b0;
      ack2_d    = 1'b0;
    end else begin
      irr_d     = (irr_q | req_set_s) & ~ack_set_s;
      isr_d     = (isr_q & ~(eoi_clr_s | aeoi_clr_s)) | ack_set_s;
      imr_d     = ocw_wr[OCW1_BIT] ? wr_data : imr_q;
      ir_prev_d = ir;
      ltim_d    = ltim_q;
      base_d    = icw_wr[ICW2_BIT] ? wr_data[7:3] : base_q;
      int_out_d = (state_q == ST_IDLE) && !inta_fall_s && qualify_s;
      ack2_d    = (state_d == ST_ACK2);
    end
  end

  // State and register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      irr_q     <= 8'h00;
      isr_q     <= 8'h00;
      imr_q     <= 8'h00;
      ir_prev_q <= 8'h00;
      ltim_q    <= 1'b0;
      base_q    <= 5'd0;
      level_q   <= 3'd0;
      vector_q  <= 8'h00;
      int_out_q <= 1'b0;
      ack2_q    <= 1'b0;
      inta_n_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      irr_q     <= irr_d;
      isr_q     <= isr_d;
      imr_q     <= imr_d;
      ir_prev_q <= ir_prev_d;
      ltim_q    <= ltim_d;
      base_q    <= base_d;
      level_q   <= level_d;
      vector_q  <= vector_d;
      int_out_q <= int_out_d;
      ack2_q    <= ack2_d;
      inta_n_q  <= inta_n;
    end
  end

  // Vector is driven only while INTA is still low inside ACK2.
  assign iv_ready         = ack2_q & ~inta_n;
  assign int_out          = int_out_q;
  assign interrupt_vector = vector_q;
  assign irr              = irr_q;
  assign isr              = isr_q;
  assign imr              = imr_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer with a transaction-level reference model.
module tb_interrupt_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ir;
  logic       inta_n;
  logic [3:0] icw_wr;
  logic [2:0] ocw_wr;
  logic [7:0] wr_data;
  logic       int_out;
  logic [7:0] interrupt_vector;
  logic       iv_ready;
  logic [7:0] irr, isr, imr;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_irr, m_isr, m_imr;
  logic [4:0] m_base;

  interrupt_sequencer #(.NUM_IR(8)) dut (
    .clk(clk), .rst(rst), .ir(ir), .inta_n(inta_n), .icw_wr(icw_wr), .ocw_wr(ocw_wr),
    .wr_data(wr_data), .int_out(int_out), .interrupt_vector(interrupt_vector),
    .iv_ready(iv_ready), .irr(irr), .isr(isr), .imr(imr)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wr_icw(input int idx, input logic [7:0] d);
    icw_wr = 4'b0001 << idx; wr_data = d; cyc(1); icw_wr = 4'b0000; wr_data = 8'h00;
  endtask

  task automatic wr_ocw(input int idx, input logic [7:0] d);
    ocw_wr = 3'b001 << idx; wr_data = d; cyc(1); ocw_wr = 3'b000; wr_data = 8'h00;
  endtask

  task automatic pulse_ir(input logic [7:0] mask);
    ir = mask; cyc(1); ir = 8'h00;
  endtask

  task automatic init_pic();
    wr_icw(0, 8'h13); wr_icw(1, 8'h40); wr_ocw(0, 8'h00);
  endtask

  // Two INTA pulses; returns the vector seen while iv_ready should be up,
  // iv_ready samples {after release, 2nd low, gap, 1st low} and ISR mid-handshake.
  task automatic do_inta(input logic [7:0] ir_at_fall, input logic [7:0] ir_after,
                         output logic [7:0] vec, output logic [3:0] ivr, output logic [7:0] isr_mid);
    inta_n = 1'b0; ir = ir_at_fall; cyc(1); ir = ir_after;
    #1 ivr[0] = iv_ready; cyc(1);
    inta_n = 1'b1; cyc(1);
    #1 ivr[1] = iv_ready; cyc(1);
    inta_n = 1'b0; cyc(1);
    #1 ivr[2] = iv_ready; vec = interrupt_vector; isr_mid = isr; cyc(1);
    inta_n = 1'b1;
    #1 ivr[3] = iv_ready; cyc(1);
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction

  task automatic test_reset();
    rst = 1'b1; cyc(3); rst = 1'b0; cyc(1);
    total++; if (int_out !== 1'b0) begin bad++; $display("FAIL reset_int got=%b exp=0", int_out); end
    total++; if (iv_ready !== 1'b0) begin bad++; $display("FAIL reset_ivr got=%b exp=0", iv_ready); end
    total++; if ({interrupt_vector, irr, isr, imr} !== 32'h0) begin bad++;
      $display("FAIL reset_regs got=%h exp=00000000", {interrupt_vector, irr, isr, imr}); end
  endtask

  task automatic test_basic();
    logic [7:0] vec, im; logic [3:0] ivr;
    init_pic(); pulse_ir(8'h08);
    total++; if (irr !== 8'h08) begin bad++; $display("FAIL basic_irr got=%h exp=08", irr); end
    total++; if (int_out !== 1'b0) begin bad++; $display("FAIL basic_int_early got=%b exp=0", int_out); end
    cyc(1);
    total++; if (int_out !== 1'b1) begin bad++; $display("FAIL basic_int got=%b exp=1", int_out); end
    do_inta(8'h00, 8'h00, vec, ivr, im);
    total++; if (vec !== 8'h43) begin bad++; $display("FAIL basic_vec got=%h exp=43", vec); end
    total++; if (ivr !== 4'b0100) begin bad++; $display("FAIL basic_ivr got=%b exp=0100", ivr); end
    total++; if ({isr, irr} !== 16'h0800) begin bad++; $display("FAIL basic_isr_irr got=%h exp=0800", {isr, irr}); end
    cyc(1);
    total++; if (int_out !== 1'b0) begin bad++; $display("FAIL basic_int_after got=%b exp=0", int_out); end
    wr_ocw(1, 8'h20);
    total++; if (isr !== 8'h00) begin bad++; $display("FAIL basic_eoi got=%h exp=00", isr); end
  endtask

  task automatic test_priority();
    logic [7:0] vec, im; logic [3:0] ivr;
    pulse_ir(8'h24); cyc(1);
    total++; if (int_out !== 1'b1) begin bad++; $display("FAIL prio_int got=%b exp=1", int_out); end
    do_inta(8'h00, 8'h00, vec, ivr, im);
    total++; if (vec !== 8'h42) begin bad++; $display("FAIL prio_vec1 got=%h exp=42", vec); end
    total++; if ({isr, irr} !== 16'h0420) begin bad++; $display("FAIL prio_regs got=%h exp=0420", {isr, irr}); end
    cyc(2);
    total++; if (int_out !== 1'b0) begin bad++; $display("FAIL prio_blocked got=%b exp=0", int_out); end
    wr_ocw(1, 8'h20);
    total++; if (isr !== 8'h00) begin bad++; $display("FAIL prio_eoi got=%h exp=00", isr); end
    cyc(1);
    total++; if (int_out !== 1'b1) begin bad++; $display("FAIL prio_int5 got=%b exp=1", int_out); end
    do_inta(8'h00, 8'h00, vec, ivr, im);
    total++; if (vec !== 8'h45) begin bad++; $display("FAIL prio_vec2 got=%h exp=45", vec); end
    wr_ocw(1, 8'h20);
  endtask

  task automatic test_mask();
    logic [7:0] vec, im; logic [3:0] ivr;
    wr_ocw(0, 8'h08); pulse_ir(8'h08); cyc(2);
    total++; if ({int_out, irr} !== 9'h008) begin bad++; $display("FAIL mask_hold got=%h exp=008", {int_out, irr}); end
    wr_ocw(0, 8'h00);
    total++; if (int_out !== 1'b0) begin bad++; $display("FAIL mask_int_1 got=%b exp=0", int_out); end
    cyc(1);
    total++; if (int_out !== 1'b1) begin bad++; $display("FAIL mask_int_2 got=%b exp=1", int_out); end
    do_inta(8'h00, 8'h00, vec, ivr, im);
    total++; if (vec !== 8'h43) begin bad++; $display("FAIL mask_vec got=%h exp=43", vec); end
    wr_ocw(1, 8'h20);
  endtask

  task automatic test_spurious_specific();
    logic [7:0] vec, im; logic [3:0] ivr;
    pulse_ir(8'h10); cyc(1);
    do_inta(8'h00, 8'h00, vec, ivr, im);
    total++; if ({vec, isr} !== 16'h4410) begin bad++; $display("FAIL ir4_service got=%h exp=4410", {vec, isr}); end
    do_inta(8'h00, 8'h00, vec, ivr, im);
    total++; if (vec !== 8'h47) begin bad++; $display("FAIL spur_vec got=%h exp=47", vec); end
    total++; if ({im, isr} !== 16'h1010) begin bad++; $display("FAIL spur_isr got=%h exp=1010", {im, isr}); end
    pulse_ir(8'h40); cyc(2);
    total++; if ({int_out, irr} !== 9'h040) begin bad++; $display("FAIL sp_blocked got=%h exp=040", {int_out, irr}); end
    wr_ocw(1, 8'h64);
    total++; if (isr !== 8'h00) begin bad++; $display("FAIL sp_eoi got=%h exp=00", isr); end
    cyc(1);
    total++; if (int_out !== 1'b1) begin bad++; $display("FAIL sp_int got=%b exp=1", int_out); end
    do_inta(8'h00, 8'h00, vec, ivr, im);
    total++; if (vec !== 8'h46) begin bad++; $display("FAIL sp_vec6 got=%h exp=46", vec); end
    wr_ocw(1, 8'h20);
  endtask

  task automatic test_edge_clear_and_level();
    logic [7:0] vec, im; logic [3:0] ivr;
    pulse_ir(8'h04); cyc(1);
    do_inta(8'h44, 8'h00, vec, ivr, im);
    total++; if ({vec, irr} !== 16'h4240) begin bad++; $display("FAIL edge_lost got=%h exp=4240", {vec, irr}); end
    wr_ocw(1, 8'h20);
    do_inta(8'h00, 8'h00, vec, ivr, im);
    wr_ocw(1, 8'h20);
    wr_icw(0, 8'h1B); ir = 8'h02; cyc(1);
    total++; if (irr !== 8'h02) begin bad++; $display("FAIL level_irr got=%h exp=02", irr); end
    do_inta(8'h02, 8'h02, vec, ivr, im);
    total++; if ({vec, isr, irr} !== 24'h410202) begin bad++;
      $display("FAIL level_relatch got=%h exp=410202", {vec, isr, irr}); end
    ir = 8'h00; wr_icw(0, 8'h13);
    total++; if ({irr, isr} !== 16'h0000) begin bad++; $display("FAIL icw1_clear got=%h exp=0000", {irr, isr}); end
  endtask

  task automatic test_random();
    logic [7:0] vec, im, p, exp_vec; logic [3:0] ivr; int lvl, pick, l; logic exp_int;
    init_pic();
    m_irr = 8'h00; m_isr = 8'h00; m_base = 5'h08;
    for (int it = 0; it < 30; it++) begin
      m_imr = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
      wr_ocw(0, m_imr);
      p = 8'($urandom_range(0, 255));
      pulse_ir(p); m_irr = m_irr | p; cyc(1);
      exp_int = (lowest(m_irr & ~m_imr) < lowest(m_isr));
      total++; if (irr !== m_irr) begin bad++; $display("FAIL rnd_irr it=%0d got=%h exp=%h", it, irr, m_irr); end
      total++; if (int_out !== exp_int) begin bad++; $display("FAIL rnd_int it=%0d got=%b exp=%b", it, int_out, exp_int); end
      do_inta(8'h00, 8'h00, vec, ivr, im);
      if (exp_int) begin
        lvl = lowest(m_irr & ~m_imr);
        m_isr[lvl] = 1'b1; m_irr[lvl] = 1'b0;
      end else begin
        lvl = 7;
      end
      exp_vec = {m_base, 3'(lvl)};
      total++; if (vec !== exp_vec) begin bad++; $display("FAIL rnd_vec it=%0d got=%h exp=%h", it, vec, exp_vec); end
      total++; if ({isr, irr} !== {m_isr, m_irr}) begin bad++;
        $display("FAIL rnd_regs it=%0d got=%h exp=%h", it, {isr, irr}, {m_isr, m_irr}); end
      pick = $urandom_range(0, 2);
      l = $urandom_range(0, 7);
      if (pick == 0) begin
        wr_ocw(1, 8'h20);
        if (lowest(m_isr) < 8) m_isr[lowest(m_isr)] = 1'b0;
      end else if (pick == 1) begin
        wr_ocw(1, 8'h60 | 8'(l)); m_isr[l] = 1'b0;
      end else begin
        wr_ocw(1, 8'hA0 | 8'(l));
      end
      total++; if (isr !== m_isr) begin bad++; $display("FAIL rnd_eoi it=%0d got=%h exp=%h", it, isr, m_isr); end
    end
  endtask

`ifdef PIC_AUTO_EOI_EN
  task automatic test_aeoi();
    logic [7:0] vec, im; logic [3:0] ivr;
    wr_icw(0, 8'h13); wr_icw(1, 8'h40); wr_icw(3, 8'h03);
    pulse_ir(8'h02); cyc(1);
    do_inta(8'h00, 8'h00, vec, ivr, im);
    total++; if ({vec, im} !== 16'h4102) begin bad++; $display("FAIL aeoi_mid got=%h exp=4102", {vec, im}); end
    total++; if (isr !== 8'h00) begin bad++; $display("FAIL aeoi_clear got=%h exp=00", isr); end
  endtask
`endif

  task automatic test_rst_mid();
    logic [7:0] vec, im; logic [3:0] ivr;
    init_pic(); wr_ocw(0, 8'h80); pulse_ir(8'h02); cyc(1);
    inta_n = 1'b0; cyc(1); inta_n = 1'b1; cyc(1);
    total++; if (isr !== 8'h02) begin bad++; $display("FAIL rstmid_ack1 got=%h exp=02", isr); end
    rst = 1'b1; cyc(1); rst = 1'b0;
    total++; if ({int_out, iv_ready} !== 2'b00) begin bad++; $display("FAIL rstmid_outs got=%b exp=00", {int_out, iv_ready}); end
    total++; if ({interrupt_vector, irr, isr, imr} !== 32'h0) begin bad++;
      $display("FAIL rstmid_regs got=%h exp=00000000", {interrupt_vector, irr, isr, imr}); end
    cyc(1);
    do_inta(8'h00, 8'h00, vec, ivr, im);
    total++; if ({vec, ivr} !== 12'h074) begin bad++; $display("FAIL rstmid_idle got=%h exp=074", {vec, ivr}); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ir = 8'h00; inta_n = 1'b1; icw_wr = 4'b0000; ocw_wr = 3'b000; wr_data = 8'h00;
    test_reset();
    test_basic();
    test_priority();
    test_mask();
    test_spurious_specific();
    test_edge_clear_and_level();
    test_random();
`ifdef PIC_AUTO_EOI_EN
    test_aeoi();
`endif
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
